// File: rtl/fv_ex_queue_mc.sv
// Multi-issue / multi-commit execution-tracking queue for the formal core model.
// Tracks per-entry expected/received kill flags and flags protocol errors combinationally.
module fv_ex_queue_mc #(
    parameter int INSTR_WIDTH = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH       = 8,
    parameter int PUSH_W      = 2,
    parameter int COMMIT_W    = 2,
    localparam int SZW        = $clog2(INSTR_WIDTH) + 1,
    localparam int PW         = $clog2(DEPTH),
    localparam int CW         = PW + 1
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic [PUSH_W-1:0]              push_valid,
    input  logic [PUSH_W*INSTR_WIDTH-1:0]  push_instr,
    input  logic [PUSH_W*ADDR_WIDTH-1:0]   push_pc,
    input  logic [PUSH_W*SZW-1:0]          push_size,
    input  logic [PUSH_W-1:0]              push_expects_kill,
    input  logic [PUSH_W-1:0]              push_is_branch,
    output logic                           push_ready,
    input  logic [COMMIT_W-1:0]            commit_valid,
    input  logic                           kill_valid,
    input  logic [PW-1:0]                  kill_offset,
    input  logic                           flush,
    output logic [COMMIT_W-1:0]            head_valid,
    output logic [COMMIT_W*INSTR_WIDTH-1:0] head_instr,
    output logic [COMMIT_W*ADDR_WIDTH-1:0] head_pc,
    output logic [COMMIT_W*SZW-1:0]        head_size,
    output logic [COMMIT_W-1:0]            head_is_branch,
    output logic [COMMIT_W-1:0]            head_expects_kill,
    output logic [COMMIT_W-1:0]            head_received_kill,
    output logic [CW-1:0]                  count,
    output logic                           full,
    output logic                           empty,
    output logic [COMMIT_W-1:0]            err_commit_empty,
    output logic                           err_commit_gap,
    output logic                           err_push_overflow,
    output logic                           err_kill_range,
    output logic [COMMIT_W-1:0]            err_kill_missing,
    output logic [COMMIT_W-1:0]            err_kill_unexpected
);

    logic [INSTR_WIDTH-1:0] instr_q  [DEPTH];
    logic [ADDR_WIDTH-1:0]  pc_q     [DEPTH];
    logic [SZW-1:0]         size_q   [DEPTH];
    logic [DEPTH-1:0]       ek_q;
    logic [DEPTH-1:0]       br_q;
    logic [DEPTH-1:0]       rk_q, rk_d;

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [PW-1:0] lane_idx [PUSH_W];
    logic [PW-1:0] slot_idx [COMMIT_W];
    logic [PW-1:0] idx_run;
    logic [PW-1:0] kill_idx;
    logic [CW-1:0] push_n, push_add;
    logic [CW-1:0] commit_k, commit_n;
    logic          do_push;
    logic          kill_ok;

    // Push lanes are compacted: each valid lane takes the next free slot after tail.
    always_comb begin
        push_n  = '0;
        idx_run = tail_q;
        for (int l = 0; l < PUSH_W; l++) begin
            lane_idx[l] = idx_run;
            if (push_valid[l]) begin
                push_n  = push_n + CW'(1);
                idx_run = idx_run + PW'(1);
            end
        end
        commit_k = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            if (commit_valid[i]) commit_k = commit_k + CW'(1);
        end
    end

    assign push_ready        = (CW'(DEPTH) - count_q) >= CW'(PUSH_W);
    assign do_push           = push_ready && (|push_valid);
    assign err_push_overflow = !push_ready && (|push_valid);
    assign push_add          = do_push ? push_n : '0;
    assign commit_n          = (commit_k < count_q) ? commit_k : count_q;

    assign kill_ok        = kill_valid && ({1'b0, kill_offset} < count_q);
    assign err_kill_range = kill_valid && !kill_ok;
    assign kill_idx       = head_q + kill_offset;

    assign head_d  = head_q + commit_n[PW-1:0];
    assign tail_d  = tail_q + push_add[PW-1:0];
    assign count_d = count_q + push_add - commit_n;

    // Fresh pushes clear received_kill; a live kill target can never be a push slot.
    always_comb begin
        rk_d = rk_q;
        if (kill_ok) rk_d[kill_idx] = 1'b1;
        for (int l = 0; l < PUSH_W; l++) begin
            if (do_push && push_valid[l]) rk_d[lane_idx[l]] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rk_q    <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rk_q    <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            rk_q    <= rk_d;
        end
    end

    // Payload carries no reset; it is only observed behind head_valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            for (int l = 0; l < PUSH_W; l++) begin
                if (push_valid[l]) begin
                    instr_q[lane_idx[l]] <= push_instr[l*INSTR_WIDTH +: INSTR_WIDTH];
                    pc_q[lane_idx[l]]    <= push_pc[l*ADDR_WIDTH +: ADDR_WIDTH];
                    size_q[lane_idx[l]]  <= push_size[l*SZW +: SZW];
                    ek_q[lane_idx[l]]    <= push_expects_kill[l];
                    br_q[lane_idx[l]]    <= push_is_branch[l];
                end
            end
        end
    end

    always_comb begin
        head_valid          = '0;
        head_instr          = '0;
        head_pc             = '0;
        head_size           = '0;
        head_is_branch      = '0;
        head_expects_kill   = '0;
        head_received_kill  = '0;
        err_commit_empty    = '0;
        err_commit_gap      = 1'b0;
        err_kill_missing    = '0;
        err_kill_unexpected = '0;
        for (int i = 0; i < COMMIT_W; i++) begin
            slot_idx[i]           = head_q + PW'(i);
            head_valid[i]         = CW'(i) < count_q;
            head_instr[i*INSTR_WIDTH +: INSTR_WIDTH] = instr_q[slot_idx[i]];
            head_pc[i*ADDR_WIDTH +: ADDR_WIDTH]      = pc_q[slot_idx[i]];
            head_size[i*SZW +: SZW]                  = size_q[slot_idx[i]];
            head_is_branch[i]     = br_q[slot_idx[i]];
            head_expects_kill[i]  = ek_q[slot_idx[i]];
            // Same-cycle kill is visible so a kill landing with its commit is not missed.
            head_received_kill[i] = rk_q[slot_idx[i]] | (kill_valid && (kill_offset == PW'(i)));
            err_commit_empty[i]   = commit_valid[i] && !head_valid[i];
            err_kill_missing[i]   = commit_valid[i] && head_valid[i] &&
                                    head_expects_kill[i] && !head_received_kill[i];
            err_kill_unexpected[i] = commit_valid[i] && head_valid[i] &&
                                     !head_expects_kill[i] && head_received_kill[i];
            if (i > 0) begin
                if (commit_valid[i] && !commit_valid[i-1]) err_commit_gap = 1'b1;
            end
        end
    end

    assign count = count_q;
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

endmodule

// File: tb/tb_fv_ex_queue_mc.sv
// Directed bench for fv_ex_queue_mc: vector table plus hand-written fill, wrap, flush and reset sequences.
module tb_fv_ex_queue_mc;

    localparam int IW = 32;
    localparam int AW = 32;
    localparam int SZW = 6;

    logic          clk;
    logic          rstn;
    logic [1:0]    push_valid;
    logic [63:0]   push_instr;
    logic [63:0]   push_pc;
    logic [11:0]   push_size;
    logic [1:0]    push_expects_kill;
    logic [1:0]    push_is_branch;
    logic          push_ready;
    logic [1:0]    commit_valid;
    logic          kill_valid;
    logic [2:0]    kill_offset;
    logic          flush;
    logic [1:0]    head_valid;
    logic [63:0]   head_instr;
    logic [63:0]   head_pc;
    logic [11:0]   head_size;
    logic [1:0]    head_is_branch;
    logic [1:0]    head_expects_kill;
    logic [1:0]    head_received_kill;
    logic [3:0]    count;
    logic          full;
    logic          empty;
    logic [1:0]    err_commit_empty;
    logic          err_commit_gap;
    logic          err_push_overflow;
    logic          err_kill_range;
    logic [1:0]    err_kill_missing;
    logic [1:0]    err_kill_unexpected;

    fv_ex_queue_mc dut (
        .clk                 (clk),
        .rstn                (rstn),
        .push_valid          (push_valid),
        .push_instr          (push_instr),
        .push_pc             (push_pc),
        .push_size           (push_size),
        .push_expects_kill   (push_expects_kill),
        .push_is_branch      (push_is_branch),
        .push_ready          (push_ready),
        .commit_valid        (commit_valid),
        .kill_valid          (kill_valid),
        .kill_offset         (kill_offset),
        .flush               (flush),
        .head_valid          (head_valid),
        .head_instr          (head_instr),
        .head_pc             (head_pc),
        .head_size           (head_size),
        .head_is_branch      (head_is_branch),
        .head_expects_kill   (head_expects_kill),
        .head_received_kill  (head_received_kill),
        .count               (count),
        .full                (full),
        .empty               (empty),
        .err_commit_empty    (err_commit_empty),
        .err_commit_gap      (err_commit_gap),
        .err_push_overflow   (err_push_overflow),
        .err_kill_range      (err_kill_range),
        .err_kill_missing    (err_kill_missing),
        .err_kill_unexpected (err_kill_unexpected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  pv;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic [1:0]  ek;
        logic [1:0]  cv;
        logic        kv;
        logic [2:0]  koff;
        logic [3:0]  e_cnt;
        logic [1:0]  e_hv;
        logic [31:0] e_pc0;
        logic [31:0] e_pc1;
        logic [1:0]  e_ce;
        logic        e_gap;
        logic        e_kr;
        logic [1:0]  e_km;
        logic [1:0]  e_ku;
    } vec_t;

    vec_t vecs[18];
    logic [31:0] exp_q[$];
    int n_checks = 0;
    int n_fail = 0;

    function automatic vec_t mk(logic [1:0] pv, logic [31:0] pc0, logic [31:0] pc1, logic [1:0] ek,
                                logic [1:0] cv, logic kv, logic [2:0] koff,
                                logic [3:0] e_cnt, logic [1:0] e_hv, logic [31:0] e_pc0, logic [31:0] e_pc1,
                                logic [1:0] e_ce, logic e_gap, logic e_kr, logic [1:0] e_km, logic [1:0] e_ku);
        vec_t v;
        v.pv = pv; v.pc0 = pc0; v.pc1 = pc1; v.ek = ek; v.cv = cv; v.kv = kv; v.koff = koff;
        v.e_cnt = e_cnt; v.e_hv = e_hv; v.e_pc0 = e_pc0; v.e_pc1 = e_pc1;
        v.e_ce = e_ce; v.e_gap = e_gap; v.e_kr = e_kr; v.e_km = e_km; v.e_ku = e_ku;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] pv, input logic [31:0] pc0, input logic [31:0] pc1,
                         input logic [1:0] ek, input logic [1:0] cv, input logic kv,
                         input logic [2:0] koff, input logic fl);
        push_valid        = pv;
        push_pc           = {pc1, pc0};
        push_instr        = {~pc1, ~pc0};
        push_size         = {6'd4, 6'd4};
        push_expects_kill = ek;
        push_is_branch    = 2'b00;
        commit_valid      = cv;
        kill_valid        = kv;
        kill_offset       = koff;
        flush             = fl;
    endtask

    task automatic idle();
        drive(2'b00, 32'h0, 32'h0, 2'b00, 2'b00, 1'b0, 3'd0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Table: expectations describe the state and combinational outputs before the edge.
        vecs[0]  = mk(2'b00, 32'h0,    32'h0,   2'b00, 2'b00, 1'b0, 3'd0, 4'd0, 2'b00, 32'h0,   32'h0,   2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
        vecs[1]  = mk(2'b11, 32'h100,  32'h104, 2'b00, 2'b00, 1'b0, 3'd0, 4'd0, 2'b00, 32'h0,   32'h0,   2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
        vecs[2]  = mk(2'b00, 32'h0,    32'h0,   2'b00, 2'b00, 1'b0, 3'd0, 4'd2, 2'b11, 32'h100, 32'h104, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
        vecs[3]  = mk(2'b10, 32'hdead, 32'h200, 2'b00, 2'b00, 1'b0, 3'd0, 4'd2, 2'b11, 32'h100, 32'h104, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
        vecs[4]  = mk(2'b00, 32'h0,    32'h0,   2'b00, 2'b00, 1'b1, 3'd5, 4'd3, 2'b11, 32'h100, 32'h104, 2'b00, 1'b0, 1'b1, 2'b00, 2'b00);
        vecs[5]  = mk(2'b00, 32'h0,    32'h0,   2'b00, 2'b11, 1'b0, 3'd0, 4'd3, 2'b11, 32'h100, 32'h104, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
        vecs[6]  = mk(2'b00, 32'h0,    32'h0,   2'b00, 2'b00, 1'b1, 3'd0, 4'd1, 2'b01, 32'h200, 32'h0,   2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
        vecs[7]  = mk(2'b00, 32'h0,    32'h0,   2'b00, 2'b11, 1'b0, 3'd0, 4'd1, 2'b01, 32'h200, 32'h0,   2'b10, 1'b0, 1'b0, 2'b00, 2'b01);
        vecs[8]  = mk(2'b00, 32'h0,    32'h0,   2'b00, 2'b00, 1'b0, 3'd0, 4'd0, 2'b00, 32'h0,   32'h0,   2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
        vecs[9]  = mk(2'b00, 32'h0,    32'h0,   2'b00, 2'b10, 1'b0, 3'd0, 4'd0, 2'b00, 32'h0,   32'h0,   2'b10, 1'b1, 1'b0, 2'b00, 2'b00);
        vecs[10] = mk(2'b11, 32'h300,  32'h304, 2'b01, 2'b00, 1'b0, 3'd0, 4'd0, 2'b00, 32'h0,   32'h0,   2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
        vecs[11] = mk(2'b00, 32'h0,    32'h0,   2'b00, 2'b01, 1'b0, 3'd0, 4'd2, 2'b11, 32'h300, 32'h304, 2'b00, 1'b0, 1'b0, 2'b01, 2'b00);
        vecs[12] = mk(2'b11, 32'h400,  32'h404, 2'b01, 2'b00, 1'b0, 3'd0, 4'd1, 2'b01, 32'h304, 32'h0,   2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
        vecs[13] = mk(2'b00, 32'h0,    32'h0,   2'b00, 2'b11, 1'b1, 3'd1, 4'd3, 2'b11, 32'h304, 32'h400, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
        vecs[14] = mk(2'b01, 32'h500,  32'h0,   2'b01, 2'b00, 1'b0, 3'd0, 4'd1, 2'b01, 32'h404, 32'h0,   2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
        vecs[15] = mk(2'b00, 32'h0,    32'h0,   2'b00, 2'b01, 1'b0, 3'd0, 4'd2, 2'b11, 32'h404, 32'h500, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
        vecs[16] = mk(2'b00, 32'h0,    32'h0,   2'b00, 2'b01, 1'b1, 3'd0, 4'd1, 2'b01, 32'h500, 32'h0,   2'b00, 1'b0, 1'b0, 2'b00, 2'b00);
        vecs[17] = mk(2'b00, 32'h0,    32'h0,   2'b00, 2'b00, 1'b0, 3'd0, 4'd0, 2'b00, 32'h0,   32'h0,   2'b00, 1'b0, 1'b0, 2'b00, 2'b00);

        rstn = 1'b0;
        idle();
        #1;
        chk("rst_count", count, 4'd0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_full", full, 1'b0);
        chk("rst_ready", push_ready, 1'b1);
        chk("rst_head_valid", head_valid, 2'b00);
        chk("rst_errs", {err_commit_empty, err_commit_gap, err_push_overflow, err_kill_range,
                         err_kill_missing, err_kill_unexpected}, 9'd0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 18; v++) begin
            drive(vecs[v].pv, vecs[v].pc0, vecs[v].pc1, vecs[v].ek, vecs[v].cv, vecs[v].kv, vecs[v].koff, 1'b0);
            #1;
            chk($sformatf("v%0d_count", v), count, vecs[v].e_cnt);
            chk($sformatf("v%0d_empty", v), empty, vecs[v].e_cnt == 4'd0);
            chk($sformatf("v%0d_ready", v), push_ready, vecs[v].e_cnt <= 4'd6);
            chk($sformatf("v%0d_head_valid", v), head_valid, vecs[v].e_hv);
            if (vecs[v].e_hv[0]) chk($sformatf("v%0d_head_pc0", v), head_pc[31:0], vecs[v].e_pc0);
            if (vecs[v].e_hv[1]) chk($sformatf("v%0d_head_pc1", v), head_pc[63:32], vecs[v].e_pc1);
            chk($sformatf("v%0d_commit_empty", v), err_commit_empty, vecs[v].e_ce);
            chk($sformatf("v%0d_commit_gap", v), err_commit_gap, vecs[v].e_gap);
            chk($sformatf("v%0d_kill_range", v), err_kill_range, vecs[v].e_kr);
            chk($sformatf("v%0d_kill_missing", v), err_kill_missing, vecs[v].e_km);
            chk($sformatf("v%0d_kill_unexpected", v), err_kill_unexpected, vecs[v].e_ku);
            chk($sformatf("v%0d_overflow", v), err_push_overflow, 1'b0);
            step();
        end

        // Fill to DEPTH with four double pushes.
        for (int c = 0; c < 4; c++) begin
            drive(2'b11, 32'h1000 + 32'(8*c), 32'h1004 + 32'(8*c), 2'b00, 2'b00, 1'b0, 3'd0, 1'b0);
            step();
        end
        idle();
        #1;
        chk("fill_count", count, 4'd8);
        chk("fill_full", full, 1'b1);
        chk("fill_ready", push_ready, 1'b0);

        drive(2'b11, 32'h2000, 32'h2004, 2'b00, 2'b00, 1'b0, 3'd0, 1'b0);
        #1;
        chk("ovf_err", err_push_overflow, 1'b1);
        step();
        idle();
        #1;
        chk("ovf_count", count, 4'd8);
        chk("ovf_pc0", head_pc[31:0], 32'h1000);

        drive(2'b00, 32'h0, 32'h0, 2'b00, 2'b11, 1'b0, 3'd0, 1'b0);
        #1;
        chk("drain_pc1", head_pc[63:32], 32'h1004);
        step();
        for (int c = 2; c < 8; c++) exp_q.push_back(32'h1000 + 32'(4*c));

        // Steady push-2/commit-2 across several pointer wraps.
        for (int c = 0; c < 20; c++) begin
            drive(2'b11, 32'h3000 + 32'(8*c), 32'h3004 + 32'(8*c), 2'b00, 2'b11, 1'b0, 3'd0, 1'b0);
            #1;
            chk($sformatf("wrap%0d_count", c), count, 4'd6);
            chk($sformatf("wrap%0d_pc0", c), head_pc[31:0], exp_q[0]);
            chk($sformatf("wrap%0d_pc1", c), head_pc[63:32], exp_q[1]);
            void'(exp_q.pop_front());
            void'(exp_q.pop_front());
            exp_q.push_back(32'h3000 + 32'(8*c));
            exp_q.push_back(32'h3004 + 32'(8*c));
            step();
        end
        idle();
        #1;
        chk("wrap_end_pc0", head_pc[31:0], exp_q[0]);

        drive(2'b11, 32'h4000, 32'h4004, 2'b00, 2'b00, 1'b0, 3'd0, 1'b1);
        step();
        idle();
        #1;
        chk("flush_count", count, 4'd0);
        chk("flush_empty", empty, 1'b1);
        chk("flush_head_valid", head_valid, 2'b00);

        drive(2'b11, 32'h5000, 32'h5004, 2'b00, 2'b00, 1'b0, 3'd0, 1'b0);
        step();
        idle();
        #1;
        chk("pre_rst_count", count, 4'd2);
        #1;
        rstn = 1'b0;
        #1;
        chk("async_rst_empty", empty, 1'b1);
        chk("async_rst_count", count, 4'd0);
        chk("async_rst_head_valid", head_valid, 2'b00);
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("post_rst_ready", push_ready, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fv_ex_queue_mc.md
# fv_ex_queue_mc

Parametrised execution-tracking queue for the formal-verification core model. It generalises the single-entry-per-cycle EX queue to `PUSH_W` issues and `COMMIT_W` commits per cycle, with configurable depth. It tracks the per-instruction expected and received kill flags, and flags commit-ordering and kill-protocol violations combinationally so that assertions can bind to them directly. It sits between the instruction-fetch constraint model and the commit/CF checkers.

## Interface
- `INSTR_WIDTH`, 32: instruction bits per entry.
- `ADDR_WIDTH`, 32: PC width.
- `DEPTH`, 8: number of entries. Must be a power of two and ≥ `2*COMMIT_W`.
- `PUSH_W`, 2: issue lanes per cycle.
- `COMMIT_W`, 2: commit slots per cycle.
- Derived: `SZW` = $clog2(INSTR_WIDTH)+1; `PW` = $clog2(DEPTH); `CW` = `PW`+1.
- `clk`, in, 1: clock.
- `rstn`, in, 1: reset, asynchronous, active-low.
- `push_valid`, in, `PUSH_W`: per-lane issue valid. Any bit pattern is legal.
- `push_instr`, in, `PUSH_W*INSTR_WIDTH`: lane-packed instructions.
- `push_pc`, in, `PUSH_W*ADDR_WIDTH`: lane-packed PCs.
- `push_size`, in, `PUSH_W*SZW`: size in bytes (0 = none).
- `push_expects_kill`, in, `PUSH_W`: a kill is expected for this instruction.
- `push_is_branch`, in, `PUSH_W`: pre-decoded branch flag.
- `push_ready`, out, 1: free slots ≥ `PUSH_W`.
- `commit_valid`, in, `COMMIT_W`: bit i retires entry head+i.
- `kill_valid`, in, 1; `kill_offset`, in, `PW`: mark received_kill on entry head+offset.
- `flush`, in, 1: discard all entries.
- `head_valid`, out, `COMMIT_W`: entry head+i exists.
- `head_instr`, `head_pc`, `head_size`, `head_is_branch`, `head_expects_kill`, `head_received_kill`, out, packed per slot: contents of entry head+i.
- `count`, out, `CW`; `full`, out, 1; `empty`, out, 1.
- `err_commit_empty`, out, `COMMIT_W`: slot i commits with no entry.
- `err_commit_gap`, out, 1: `commit_valid` is not contiguous from bit 0.
- `err_push_overflow`, out, 1.
- `err_kill_range`, out, 1.
- `err_kill_missing`, out, `COMMIT_W`; `err_kill_unexpected`, out, `COMMIT_W`.

## Operation
- Storage is a circular buffer with `head` and `tail` pointers of `PW` bits; wrap is modulo `DEPTH`. `count` is held in a separate `CW`-bit register.
- Push: valid lanes are compacted in ascending lane order and written at tail, tail+1, …. The tail and count advance by popcount(`push_valid`).
  - Stored per entry: `received_kill` = 0, plus the pushed `instr`, `pc`, `size`, `expects_kill` and `is_branch`.
- Push while `!push_ready` with any valid bit set: nothing is written and `err_push_overflow` = 1. There is no partial push.
- Commit: k = popcount(`commit_valid`); the head advances by min(k, `count`).
  - `err_commit_empty[i]` = `commit_valid[i]` && (i ≥ `count`).
  - `err_commit_gap` = 1 if any set bit has a clear lower bit.
- Kill: if `kill_offset` < `count`, set `received_kill` on head+`kill_offset`; otherwise `err_kill_range` = 1 and no state changes.
  - A second kill to the same entry is idempotent.
- `head_received_kill[i]` = stored bit | (`kill_valid` && `kill_offset` == i), so a kill in the same cycle as that entry's commit is seen.
- Committed slot i with `expects_kill` & !`head_received_kill` raises `err_kill_missing[i]`.
- Committed slot i with !`expects_kill` & `head_received_kill` raises `err_kill_unexpected[i]`.
- Simultaneous push and commit: both apply. `push_ready` is computed from the registered `count` only; same-cycle commits do not free space for same-cycle pushes. Next count = `count` + pushes − commits.
- Flush has priority over push, commit and kill. The next state is `head` = `tail` = 0 and all valid state cleared. Error outputs are still evaluated in the flush cycle.
- `full` = (`count` == `DEPTH`); `empty` = (`count` == 0).

## Timing
- Reset (async assert, sync-released by `clk`): `head`, `tail`, `count` = 0; all `received_kill` = 0.
  - Outputs at reset: `empty` = 1, `full` = 0, `push_ready` = 1, `head_valid` = 0, all `err_*` = 0.
  - Entry payload is not reset; `head_*` payload is don't-care while `head_valid[i]` = 0.
- Reset mid-operation drops all entries immediately.
- Push-to-head latency is 1 cycle: an entry pushed into an empty queue at edge N drives `head_valid[0]` after edge N.
- `head_*` and all `err_*` outputs are combinational from state and the current inputs. There are no registered error pulses.
- State updates only on the rising edge of `clk`.

## Test plan
- Reset, then push lanes {1,1} with PCs 0x100, 0x104 → next cycle `count` = 2, `head_pc[0]` = 0x100, `head_pc[1]` = 0x104, `empty` = 0.
- Push `push_valid` = 2'b10, PC 0x200 on lane 1 → stored at the tail as the single entry, `count` += 1.
- Fill DEPTH = 8 with 4 double pushes → `full` = 1, `push_ready` = 0. A fifth push raises `err_push_overflow` = 1, and `count` stays 8.
- Wrap-around check:
  - Commit 2 per cycle while pushing 2 per cycle for 20 cycles → `count` stays constant.
  - PCs commit in push order across the pointer wrap.
- Kill handling:
  - Entry pushed with expects_kill = 1 and committed with no kill → `err_kill_missing[0]` = 1.
  - Kill with offset 0 in the commit cycle → no error.
  - Kill to an entry with expects_kill = 0 → `err_kill_unexpected` = 1 on commit.
  - `kill_offset` = 5 with `count` = 3 → `err_kill_range` = 1.
- With `count` = 1, commit 2'b11 → `err_commit_empty` = 2'b10 and the queue becomes empty. Commit 2'b10 → `err_commit_gap` = 1.
- Flush together with a push → `count` = 0 next cycle. Assert `rstn` low mid-stream → `empty` = 1 asynchronously.
